vram_arbiter: RTL
=================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, video memory address width.
REQ-002 Parameter DATA_W, default 8, video memory data width.
REQ-003 Parameter STARVE_MAX, default 8'hFF, pending-cycle count at which starve asserts.
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 ppu_req  in  1  render fetch owns the bus this cycle.
REQ-007 ppu_a  in  ADDR_W  render fetch address.
REQ-008 ppu_din  out  DATA_W  read data returned to the renderer.
REQ-009 cpu_req  in  1  CPU-side access request, four-phase.
REQ-010 cpu_wr  in  1  1 = write, 0 = read; valid with cpu_req.
REQ-011 cpu_a  in  ADDR_W  CPU-side address.
REQ-012 cpu_wdata  in  DATA_W  CPU-side write data.
REQ-013 cpu_ack  out  1  one-cycle completion pulse.
REQ-014 cpu_rdata  out  DATA_W  registered read result; valid from cpu_ack onward.
REQ-015 starve  out  1  CPU request pending for STARVE_MAX cycles or more.
REQ-016 vram_a  out  ADDR_W  video memory address.
REQ-017 vram_wr  out  1  write strobe; the write commits at the clk edge.
REQ-018 vram_wdata  out  DATA_W  video memory write data.
REQ-019 vram_din  in  DATA_W  video memory read data; combinational from vram_a in the same cycle.

Function
REQ-020 FSM states SHALL be IDLE, PEND, DONE.
REQ-021 IDLE: on cpu_req=1, latch cpu_a, cpu_wr and cpu_wdata; go to PEND next cycle.
REQ-022 PEND with ppu_req=1: stay in PEND and do not drive the CPU access.
REQ-023 PEND with ppu_req=0 (the access cycle): drive the latched address; vram_wr = latched wr; vram_wdata = latched data; on a read, capture vram_din into cpu_rdata at the edge; go to DONE.
REQ-024 DONE: cpu_ack=1 for exactly one cycle; then wait until cpu_req=0 before returning to IDLE.
REQ-025 cpu_ack SHALL be 0 in all cycles other than the first DONE cycle.
REQ-026 Minimum latency: cpu_req seen at cycle N gives cpu_ack at cycle N+2.
REQ-027 Render priority is absolute: whenever ppu_req=1, vram_a=ppu_a, vram_wr=0 and ppu_din=vram_din, regardless of FSM state.
REQ-028 When neither side owns the bus: vram_a = latched address, vram_wr = 0, vram_wdata = latched data.
REQ-029 ppu_req is sampled combinationally; a ppu_req rising in the same cycle as a would-be access cycle wins, and no partial CPU access occurs.
REQ-030 If cpu_req drops while in PEND (protocol violation), the latched access still completes and cpu_ack still pulses once.
REQ-031 A pending counter of 8 bits increments each PEND cycle, saturates at 8'hFF, and clears on leaving PEND.
REQ-032 starve = (counter >= STARVE_MAX) while in PEND; starve = 0 otherwise.
REQ-033 vram_wr SHALL never be high for more than one cycle per CPU request.

Reset
REQ-034 While rst=1 at an edge: state=IDLE, cpu_ack=0, cpu_rdata=0, counter=0, starve=0, all latches=0.
REQ-035 Reset during PEND SHALL abandon the access with no write committed; reset during DONE SHALL suppress any further ack.
REQ-036 Combinational outputs SHALL be valid in the first cycle after reset.

Structure
REQ-037 A shared package SHALL hold the state enum, ADDR_W/DATA_W defaults and STARVE_MAX default.
REQ-038 The block is a single module with no sub-modules.

Verification
REQ-039 Idle bus, CPU write 0x2005<-0xA7 -> vram_wr high for exactly one cycle with vram_a=0x2005 and vram_wdata=0xA7; cpu_ack at N+2.
REQ-040 ppu_req held high 5 cycles, CPU read 0x23C1 issued at N -> no vram_wr; access occurs after ppu_req falls; cpu_ack at N+7; cpu_rdata = memory[0x23C1].
REQ-041 ppu_req toggling every cycle with a CPU read pending -> render addresses are never displaced; the CPU access lands in a ppu_req=0 cycle.
REQ-042 ppu_req held high 300 cycles with a CPU request pending -> starve rises 255 cycles after PEND entry and clears when the access completes.
REQ-043 rst asserted in PEND of a write to 0x2000 -> memory[0x2000] unchanged, no cpu_ack, state IDLE.
REQ-044 cpu_req held high after ack -> a single cpu_ack pulse and no second access until cpu_req=0 and is then re-asserted.

Source files
------------

// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: shared state encoding and parameter defaults for the VRAM arbiter
package vram_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, PEND, DONE} state_t;
    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 8;
    localparam logic [7:0] STARVE_MAX_DEF = 8'hFF;
endpackage

// File: rtl/vram_arbiter.sv
// vram_arbiter: render fetch has absolute bus priority; CPU accesses slip into free cycles
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter logic [7:0] STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ppu_req,
    input  logic [ADDR_W-1:0] ppu_a,
    output logic [DATA_W-1:0] ppu_din,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_a,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              starve,
    output logic [ADDR_W-1:0] vram_a,
    output logic              vram_wr,
    output logic [DATA_W-1:0] vram_wdata,
    input  logic [DATA_W-1:0] vram_din
);
    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_a;
    logic              r_wr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_ack;
    logic [7:0]        r_cnt;
    logic              w_access;

    assign w_access = (r_state == PEND) && !ppu_req;

    // next state: wait for a free bus cycle, then hold DONE until the requester lets go
    always_comb begin
        w_next = (r_state == IDLE) ? (cpu_req ? PEND : IDLE) :
                 (r_state == PEND) ? (ppu_req ? PEND : DONE) :
                                     (cpu_req ? DONE : IDLE);
    end

    // state, request latches, read capture, one-shot ack and saturating pending counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_next;
            r_ack   <= w_access;
            if (r_state == IDLE && cpu_req) begin
                r_a     <= cpu_a;
                r_wr    <= cpu_wr;
                r_wdata <= cpu_wdata;
            end
            if (w_access && !r_wr) r_rdata <= vram_din;
            r_cnt <= (r_state == PEND && w_next == PEND) ? ((r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1) : 8'd0;
        end
    end

    // rst gates the strobe so a reset landing on the access cycle commits nothing
    assign vram_a     = ppu_req ? ppu_a : r_a;
    assign vram_wr    = w_access && r_wr && !rst;
    assign vram_wdata = r_wdata;
    assign ppu_din    = vram_din;
    assign cpu_ack    = r_ack;
    assign cpu_rdata  = r_rdata;
    assign starve     = (r_state == PEND) && (r_cnt >= STARVE_MAX);
endmodule
